// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, state encoding and entry format for the PS/2 scan receiver
//
// Purpose: common definitions imported by ps2_scan_rx and ps2_fifo.
// Contents:
//   PS2_EXT / PS2_BRK  prefix bytes folded into the ext / brk flags
//   ENTRY_W            FIFO entry width, {ext, brk, code[7:0]}
//   ps2_state_t        frame FSM states
//   ps2_entry_t        packed view of one FIFO entry
//   odd_parity_ok      1 when data plus parity bit hold an odd number of ones
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int         ENTRY_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - synchronous show-ahead FIFO holding decoded scan entries
//
// Purpose: stores WIDTH-bit entries; the head entry is always visible on rd_data.
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   push, wr_data   write request and entry
//   pop             remove head entry (ignored when empty)
//   rd_data         head entry (undefined contents when empty)
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard receiver with prefix folding and entry FIFO
//
// Purpose: oversamples the PS/2 lines in the clk domain, frames 11-bit packets,
// checks odd parity and stop bit, folds E0/F0 prefixes into ext/brk and queues
// {ext,brk,code} entries.
// Ports:
//   clk, rst              system clock, synchronous active-low reset
//   ps2_clk, ps2_data     raw asynchronous PS/2 lines
//   rd_en                 pop the head entry (ignored when empty)
//   valid                 FIFO not empty
//   code, ext, brk        head entry (all 0 when empty)
//   count                 FIFO occupancy
//   parity_err            pulse: frame dropped on parity failure
//   frame_err             pulse: frame dropped on bad stop bit or timeout
//   overflow              pulse: FIFO full, decoded entry dropped
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic                          valid,
  output logic [7:0]                    code,
  output logic                          ext,
  output logic                          brk,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_LAST = FILTER_LEN - 1;
  localparam logic [FW-1:0] FLT_ONE  = 1;
  localparam logic [TW-1:0] TMO_LAST = TIMEOUT_CYC;
  localparam logic [TW-1:0] TMO_ONE  = 1;

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic clk_flt, clk_flt_d;
  logic [FW-1:0] flt_cnt;
  logic fall;

  ps2_state_t state, state_n;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          frame_done;

  logic       ext_pend, brk_pend;
  logic       push_q;
  ps2_entry_t push_data;
  ps2_entry_t head;
  logic       fifo_full, fifo_empty;

  // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock glitch filter: any sample equal to the current level restarts the run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      clk_flt_d <= clk_flt;
      if (clk_s2 == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_flt <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_ONE;
      end
    end
  end

  assign fall = clk_flt_d & ~clk_flt;

  // A fall in the same cycle counts as activity, so it wins over the timeout.
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    if (tmo_hit) begin
      state_n = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_n = DATA;
        DATA:    if (bitcnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n    = IDLE;
          frame_done = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + TMO_ONE;
      if (fall) begin
        case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY: par_bit <= dat_s2;
          default: ;
        endcase
      end
    end
  end

  // Frame check and prefix folding; the stop bit is dat_s2 on the frame_done fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      push_q     <= 1'b0;
      push_data  <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (tmo_hit) begin
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end else if (frame_done) begin
        if (!odd_parity_ok(shreg, par_bit)) begin
          parity_err <= 1'b1;
          ext_pend   <= 1'b0;
          brk_pend   <= 1'b0;
        end else if (!dat_s2) begin
          frame_err <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end else if (shreg == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (shreg == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          push_q         <= 1'b1;
          push_data.ext  <= ext_pend;
          push_data.brk  <= brk_pend;
          push_data.code <= shreg;
          ext_pend       <= 1'b0;
          brk_pend       <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) overflow <= 1'b0;
    else      overflow <= push_q && fifo_full && !(rd_en && !fifo_empty);
  end

  ps2_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .wr_data (push_data),
    .pop     (rd_en),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Mask the head so an empty FIFO presents zeros rather than stale storage.
  assign valid = !fifo_empty;
  assign code  = valid ? head.code : 8'h00;
  assign ext   = valid & head.ext;
  assign brk   = valid & head.brk;

endmodule
